// File: rtl/mic1_shift_unit.sv
`default_nettype none
// ============================================================================
// Module  : mic1_shift_unit
// Purpose : Multi-cycle shift unit for the MIC-1 datapath, sitting between
//           the ALU output and the C-bus. Performs PASS, SLL, SRA, SRL, ROL
//           and ROR by a variable amount, shifting STEP bit positions per
//           clock. Valid/ready handshakes on both sides let the
//           microsequencer stall on it. N/Z flags describe the result.
// Ports   : clk, rst                  clock, async active-high reset
//           in_valid/in_ready         request handshake
//           in_data, in_op, in_amt    operand, opcode, shift amount
//           out_valid/out_ready       result handshake
//           out_data, out_n, out_z    result and its flags
//           out_err                   request used a reserved opcode
// Revision: 1.0  initial release
// ============================================================================
module mic1_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int STEP    = 1,
    parameter int SHAMT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [2:0]         in_op,
    input  logic [SHAMT_W-1:0] in_amt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_n,
    output logic               out_z,
    output logic               out_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [SHAMT_W-1:0] WIDTH_C = SHAMT_W'(WIDTH);
    localparam logic [SHAMT_W-1:0] STEP_C  = SHAMT_W'(STEP);
    localparam logic [31:0]        WIDTH_W = 32'(WIDTH);

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_SRA  = 3'b010;
    localparam logic [2:0] OP_SRL  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic [2:0]         op;
    logic [SHAMT_W-1:0] remaining;

    logic [SHAMT_W-1:0] eff_amt;
    logic               reserved;
    logic [SHAMT_W-1:0] step_amt;
    logic [31:0]        k;
    logic [WIDTH-1:0]   stepped;

    // Effective amount: shifts saturate at WIDTH (result is then all fill
    // bits), rotates wrap modulo WIDTH, PASS/reserved need no shifting.
    always_comb begin
        reserved = 1'b0;
        eff_amt  = '0;
        case (in_op)
            OP_PASS:                eff_amt = '0;
            OP_SLL, OP_SRA, OP_SRL: eff_amt = (in_amt > WIDTH_C) ? WIDTH_C : in_amt;
            OP_ROL, OP_ROR:         eff_amt = in_amt % WIDTH_C;
            default:                reserved = 1'b1;
        endcase
    end

    // One iteration moves min(STEP, remaining) bit positions. Because the
    // working register keeps its MSB under an arithmetic shift, the sign of
    // the captured operand is preserved across all SRA iterations.
    always_comb begin
        step_amt = (remaining < STEP_C) ? remaining : STEP_C;
        k        = 32'(step_amt);
        case (op)
            OP_SLL:  stepped = work << k;
            OP_SRL:  stepped = work >> k;
            OP_SRA:  stepped = $signed(work) >>> k;
            OP_ROL:  stepped = (work << k) | (work >> (WIDTH_W - k));
            OP_ROR:  stepped = (work >> k) | (work << (WIDTH_W - k));
            default: stepped = work;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            work      <= '0;
            op        <= OP_PASS;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work      <= in_data;
                        op        <= in_op;
                        remaining <= eff_amt;
                        if (eff_amt == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= in_data;
                            out_err   <= reserved;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work      <= stepped;
                    remaining <= remaining - step_amt;
                    // Only valid opcodes ever reach SHIFT, so err is 0 here.
                    if (remaining == step_amt) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= stepped;
                        out_err   <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign out_n    = out_data[WIDTH-1];
    assign out_z    = (out_data == '0);

endmodule
`default_nettype wire

// File: tb/tb_mic1_shift_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_mic1_shift_unit
// Purpose : Self-checking bench for mic1_shift_unit. A STEP=1 instance and a
//           STEP=8 instance share operand inputs; expected results are pushed
//           to a scoreboard queue when requests are issued and popped when
//           the DUT presents a result.
// Revision: 1.0  initial release
// ============================================================================
module tb_mic1_shift_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_valid8;
    logic        in_ready, in_ready8;
    logic [31:0] in_data;
    logic [2:0]  in_op;
    logic [5:0]  in_amt;
    logic        out_valid, out_valid8;
    logic        out_ready;
    logic [31:0] out_data, out_data8;
    logic        out_n, out_n8, out_z, out_z8, out_err, out_err8;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mic1_shift_unit #(.WIDTH(32), .STEP(1), .SHAMT_W(6)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_op(in_op), .in_amt(in_amt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_n(out_n), .out_z(out_z), .out_err(out_err)
    );

    mic1_shift_unit #(.WIDTH(32), .STEP(8), .SHAMT_W(6)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .in_data(in_data), .in_op(in_op), .in_amt(in_amt),
        .out_valid(out_valid8), .out_ready(out_ready),
        .out_data(out_data8), .out_n(out_n8), .out_z(out_z8), .out_err(out_err8)
    );

    // Reference model of the result.
    function automatic logic [31:0] model_data(logic [31:0] d, logic [2:0] op, int amt);
        int e;
        case (op)
            3'd1: model_data = (amt >= 32) ? 32'h0 : (d << amt);
            3'd2: model_data = (amt >= 32) ? {32{d[31]}} : 32'($signed(d) >>> amt);
            3'd3: model_data = (amt >= 32) ? 32'h0 : (d >> amt);
            3'd4: begin
                e = amt % 32;
                model_data = (e == 0) ? d : ((d << e) | (d >> (32 - e)));
            end
            3'd5: begin
                e = amt % 32;
                model_data = (e == 0) ? d : ((d >> e) | (d << (32 - e)));
            end
            default: model_data = d;
        endcase
    endfunction

    function automatic int model_lat(logic [2:0] op, int amt, int step);
        int e;
        case (op)
            3'd1, 3'd2, 3'd3: e = (amt > 32) ? 32 : amt;
            3'd4, 3'd5:       e = amt % 32;
            default:          e = 0;
        endcase
        model_lat = (e == 0) ? 1 : ((e + step - 1) / step + 1);
    endfunction

    function automatic exp_t make_exp(logic [31:0] d, logic [2:0] op, int amt, int step);
        exp_t x;
        x.data = model_data(d, op, amt);
        x.err  = (op == 3'd6) || (op == 3'd7);
        x.lat  = model_lat(op, amt, step);
        return x;
    endfunction

    // Drive a request, push its expectation, return #1 after the accept edge.
    task automatic issue(input bit use8, input logic [31:0] d, input logic [2:0] op, input int amt);
        int guard;
        sb.push_back(make_exp(d, op, amt, use8 ? 8 : 1));
        @(negedge clk);
        in_data = d;
        in_op   = op;
        in_amt  = 6'(amt);
        if (use8) in_valid8 = 1'b1; else in_valid = 1'b1;
        guard = 0;
        while (!(use8 ? in_ready8 : in_ready) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready never rose, required 1");
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_valid8 = 1'b0;
    endtask

    // Wait for the result (called #1 after the accept edge) and check it.
    task automatic collect(input bit use8, input string name);
        int    cyc;
        exp_t  x;
        logic [31:0] d;
        cyc = 1;
        while (!(use8 ? out_valid8 : out_valid) && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        x = sb.pop_front();
        d = use8 ? out_data8 : out_data;
        total++;
        if (cyc !== x.lat) begin
            bad++;
            $display("FAIL %s latency: got %0d required %0d", name, cyc, x.lat);
        end
        total++;
        if (d !== x.data) begin
            bad++;
            $display("FAIL %s data: got %h required %h", name, d, x.data);
        end
        total++;
        if ((use8 ? out_n8 : out_n) !== x.data[31]) begin
            bad++;
            $display("FAIL %s n_flag: got %b required %b", name, use8 ? out_n8 : out_n, x.data[31]);
        end
        total++;
        if ((use8 ? out_z8 : out_z) !== (x.data == 32'h0)) begin
            bad++;
            $display("FAIL %s z_flag: got %b required %b", name, use8 ? out_z8 : out_z, x.data == 32'h0);
        end
        total++;
        if ((use8 ? out_err8 : out_err) !== x.err) begin
            bad++;
            $display("FAIL %s err: got %b required %b", name, use8 ? out_err8 : out_err, x.err);
        end
        if (out_ready) begin
            @(posedge clk);
            #1;
            total++;
            if ((use8 ? out_valid8 : out_valid) !== 1'b0 || (use8 ? out_data8 : out_data) !== x.data) begin
                bad++;
                $display("FAIL %s after_handshake: valid=%b data=%h required valid=0 data=%h",
                         name, use8 ? out_valid8 : out_valid, use8 ? out_data8 : out_data, x.data);
            end
        end
    endtask

    task automatic test_reset();
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_z !== 1'b1 || out_err !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: valid=%b data=%h z=%b err=%b rdy=%b required 0 00000000 1 0 1",
                     out_valid, out_data, out_z, out_err, in_ready);
        end
    endtask

    task automatic test_shifts();
        issue(0, 32'h0000_00AB, 3'd1, 8);  collect(0, "sll8");
        issue(0, 32'h8000_0004, 3'd2, 1);  collect(0, "sra1");
        issue(0, 32'h8000_0004, 3'd2, 63); collect(0, "sra63");
        issue(0, 32'h1234_5678, 3'd5, 4);  collect(0, "ror4");
        issue(0, 32'h1234_5678, 3'd4, 36); collect(0, "rol36");
        issue(0, 32'hFFFF_FFFF, 3'd3, 40); collect(0, "srl40");
        issue(0, 32'hA5A5_0F0F, 3'd3, 7);  collect(0, "srl7");
    endtask

    task automatic test_step8();
        issue(1, 32'hFFFF_FFFF, 3'd3, 40); collect(1, "s8_srl40");
        issue(1, 32'h0000_00AB, 3'd1, 8);  collect(1, "s8_sll8");
        issue(1, 32'h8000_0004, 3'd2, 13); collect(1, "s8_sra13");
        issue(1, 32'h1234_5678, 3'd4, 12); collect(1, "s8_rol12");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        issue(0, 32'h0000_0055, 3'd1, 2);
        collect(0, "bp_first");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'hDEAD_BEEF;
            in_op    = 3'd0;
            in_amt   = 6'd0;
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'h0000_0154 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold: valid=%b data=%h rdy=%b required 1 00000154 0",
                         out_valid, out_data, in_ready);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        sb.push_back(make_exp(32'hDEAD_BEEF, 3'd0, 0, 1));
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: valid=%b rdy=%b required 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        collect(0, "bp_second");
    endtask

    task automatic test_reset_mid_shift();
        issue(0, 32'h0000_0F0F, 3'd1, 20);
        sb.delete();
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1 || out_z !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid: valid=%b data=%h rdy=%b z=%b required 0 00000000 1 1",
                     out_valid, out_data, in_ready, out_z);
        end
        @(negedge clk);
        rst = 1'b0;
        issue(0, 32'h0000_0001, 3'd0, 0);  collect(0, "pass_after_rst");
        issue(0, 32'h0000_1234, 3'd7, 5);  collect(0, "reserved111");
        issue(0, 32'h8000_0000, 3'd6, 3);  collect(0, "reserved110");
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_valid8 = 1'b0;
        in_data   = 32'h0;
        in_op     = 3'd0;
        in_amt    = 6'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        test_reset();
        test_shifts();
        test_step8();
        test_backpressure();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
